// File: rtl/chaser_sched_if.sv
// Pipelined Wishbone link between chaser_sched (master) and the LED-chaser slave port.
interface chaser_sched_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic        o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_stall, i_wb_ack, i_wb_data
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_stall, i_wb_ack, i_wb_data
    );
endinterface

// File: rtl/chaser_sched.sv
// Round-robin scheduler sharing one LED-chaser Wishbone peripheral between NREQ requesters:
// start write, status polling until the sweep ends, then done/err and the next grant.
module chaser_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned POLL_GAP    = 64,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NREQ-1:0] i_req,
    output logic            o_busy,
    output logic [2:0]      o_grant,
    output logic            o_done,
    output logic            o_err,
    chaser_sched_if.master  wb
);
    localparam int unsigned CNT_MAX = (POLL_GAP > ACK_TIMEOUT) ? POLL_GAP : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WACK, S_GAP, S_RD, S_RACK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [NREQ-1:0]   clr;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic              found, end_run;
    logic [2:0]        pick;
    logic [2:0]        nxt_ptr;
    logic              unused_rdata;

    assign unused_rdata = ^wb.i_wb_data[31:5];
    assign nxt_ptr      = (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;

    // First pending requester at or after ptr, wrapping to the low indices.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && pending_q[k] && (3'(k) >= ptr_q)) begin
                found = 1'b1;
                pick  = 3'(k);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && pending_q[k]) begin
                found = 1'b1;
                pick  = 3'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        end_run = 1'b0;
        err_d   = 1'b0;
        clr     = '0;
        case (state_q)
            S_IDLE: if (found) begin
                grant_d = pick;
                state_d = S_WR;
            end
            S_WR: if (!wb.i_wb_stall) begin
                state_d = S_WACK;
                cnt_d   = '0;
            end
            S_WACK: begin
                if (wb.i_wb_ack) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_IDLE;
                    end_run = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD: if (!wb.i_wb_stall) begin
                state_d = S_RACK;
                cnt_d   = '0;
            end
            S_RACK: begin
                if (wb.i_wb_ack) begin
                    state_d = (wb.i_wb_data[4:0] == 5'd0) ? S_DONE : S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_IDLE;
                    end_run = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                end_run = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (end_run) begin
            ptr_d = nxt_ptr;
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (grant_q == 3'(k)) clr[k] = 1'b1;
            end
        end
        // A new request in the clearing cycle re-queues the requester.
        pending_d = (pending_q & ~clr) | i_req;

        cyc_d  = (state_d == S_WR) || (state_d == S_WACK) || (state_d == S_RD) || (state_d == S_RACK);
        stb_d  = (state_d == S_WR) || (state_d == S_RD);
        we_d   = (state_d == S_WR);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        data_d = {29'h0, grant_d};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_grant      = grant_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign wb.o_wb_cyc  = cyc_q;
    assign wb.o_wb_stb  = stb_q;
    assign wb.o_wb_we   = we_q;
    assign wb.o_wb_addr = 1'b0;
    assign wb.o_wb_data = data_q;
endmodule

// File: tb/tb_chaser_sched.sv
// Self-checking bench for chaser_sched: scripted Wishbone slave, run log, table of
// request scenarios plus hand-written latency, re-queue and reset sequences.
module tb_chaser_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned PG   = 64;
    localparam int unsigned AT   = 15;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [NREQ-1:0] i_req;
    logic            o_busy, o_done, o_err;
    logic [2:0]      o_grant;
    int              cyc_n = 0;

    chaser_sched_if wb ();

    chaser_sched #(.NREQ(NREQ), .POLL_GAP(PG), .ACK_TIMEOUT(AT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .o_busy(o_busy),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .wb(wb.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [2:0] g;
        bit         e;
        int         edge_n;
    } run_t;

    run_t        runs[$];
    int          wr_acc[$];
    int          rd_acc[$];
    logic [31:0] wr_data[$];
    int          last_wlen = 0;
    int          n_pass = 0;
    int          n_total = 0;

    // slave configuration
    int sl_wr_stall = 0;
    bit sl_no_ack   = 1'b0;
    bit sl_rd_stall = 1'b0;
    int sl_reads    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Scripted slave: optional write stall, 1-cycle ack, status counts down sl_reads nonzero reads.
    initial begin
        int          stall_left;
        int          reads_left;
        bit          pend_ack;
        logic [31:0] pend_data;
        stall_left = 0; reads_left = 0; pend_ack = 1'b0; pend_data = '0;
        wb.i_wb_stall = 1'b0; wb.i_wb_ack = 1'b0; wb.i_wb_data = '0;
        forever begin
            @(negedge clk);
            wb.i_wb_ack   = pend_ack;
            wb.i_wb_data  = pend_ack ? pend_data : 32'hFFFF_FFE7;
            wb.i_wb_stall = 1'b0;
            pend_ack      = 1'b0;
            if (i_reset) begin
                wb.i_wb_ack = 1'b0;
                stall_left  = sl_wr_stall;
            end else if (wb.o_wb_cyc && wb.o_wb_stb) begin
                if (wb.o_wb_we && stall_left > 0) begin
                    wb.i_wb_stall = 1'b1;
                    stall_left--;
                end else if (!wb.o_wb_we && sl_rd_stall) begin
                    wb.i_wb_stall = 1'b1;
                end else if (wb.o_wb_we) begin
                    wr_acc.push_back(cyc_n + 1);
                    wr_data.push_back(wb.o_wb_data);
                    pend_ack   = !sl_no_ack;
                    pend_data  = '0;
                    reads_left = sl_reads;
                    stall_left = sl_wr_stall;
                end else begin
                    rd_acc.push_back(cyc_n + 1);
                    pend_ack  = 1'b1;
                    pend_data = (reads_left > 0) ? 32'd5 : 32'd0;
                    if (reads_left > 0) reads_left--;
                end
            end
        end
    end

    // Run log and write-strobe length monitor.
    initial begin
        int  wrun;
        wrun = 0;
        forever begin
            @(negedge clk);
            if (o_done || o_err) runs.push_back('{g: o_grant, e: o_err, edge_n: cyc_n});
            if (wb.o_wb_stb && wb.o_wb_we) wrun++;
            else if (wrun > 0) begin
                last_wlen = wrun;
                wrun      = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic clear_logs();
        runs.delete(); wr_acc.delete(); rd_acc.delete(); wr_data.delete();
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        @(negedge clk);
        i_req = r;
        @(negedge clk);
        i_req = '0;
    endtask

    task automatic wait_runs(input int n);
        for (int i = 0; i < 4000 && runs.size() < n; i++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " cyc"},   32'(wb.o_wb_cyc), 32'd0);
        check({tag, " stb"},   32'(wb.o_wb_stb), 32'd0);
        check({tag, " we"},    32'(wb.o_wb_we),  32'd0);
        check({tag, " addr"},  32'(wb.o_wb_addr), 32'd0);
        check({tag, " data"},  wb.o_wb_data,     32'd0);
        check({tag, " busy"},  32'(o_busy),      32'd0);
        check({tag, " done"},  32'(o_done),      32'd0);
        check({tag, " err"},   32'(o_err),       32'd0);
        check({tag, " grant"}, 32'(o_grant),     32'd0);
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        int         wr_stall;
        bit         no_ack;
        int         reads;
        int         n_runs;
        logic [2:0] g0, g1, g2;
        int         n_wr;
        int         n_rd;
        int         wlen;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 4'b0001, 0, 1'b0, 2, 1, 3'd0, 3'd0, 3'd0, 1, 3, 1};
        vecs[1] = '{1'b1, 4'b1011, 0, 1'b0, 0, 3, 3'd0, 3'd1, 3'd3, 3, 3, 1};
        vecs[2] = '{1'b0, 4'b1001, 0, 1'b0, 0, 2, 3'd0, 3'd3, 3'd0, 2, 2, 1};
        vecs[3] = '{1'b1, 4'b0100, 7, 1'b0, 1, 1, 3'd2, 3'd0, 3'd0, 1, 2, 8};
        vecs[4] = '{1'b1, 4'b0011, 0, 1'b1, 0, 2, 3'd0, 3'd1, 3'd0, 2, 0, 1};
        vecs[5] = '{1'b0, 4'b1000, 0, 1'b0, 3, 1, 3'd3, 3'd0, 3'd0, 1, 4, 1};

        i_reset = 1'b1;
        i_req   = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Request latency, write data and poll spacing with an ideal slave.
        sl_reads = 2;
        clear_logs();
        i_req = 4'b0001;
        @(negedge clk);
        i_req = '0;
        check("lat busy t", 32'(o_busy), 32'd0);
        check("lat cyc t", 32'(wb.o_wb_cyc), 32'd0);
        @(negedge clk);
        check("lat cyc t1", 32'(wb.o_wb_cyc), 32'd1);
        check("lat stb t1", 32'(wb.o_wb_stb), 32'd1);
        check("lat we t1", 32'(wb.o_wb_we), 32'd1);
        check("lat busy t1", 32'(o_busy), 32'd1);
        wait_runs(1);
        check("lat runs", 32'(runs.size()), 32'd1);
        check("lat rd count", 32'(rd_acc.size()), 32'd3);
        if (rd_acc.size() == 3 && wr_acc.size() == 1) begin
            check("wr->rd0 gap", 32'(rd_acc[0] - wr_acc[0]), 32'(PG + 2));
            check("rd0->rd1 gap", 32'(rd_acc[1] - rd_acc[0]), 32'(PG + 2));
            check("rd1->rd2 gap", 32'(rd_acc[2] - rd_acc[1]), 32'(PG + 2));
        end

        // Table of request scenarios.
        for (int v = 0; v < 6; v++) begin
            sl_wr_stall = vecs[v].wr_stall;
            sl_no_ack   = vecs[v].no_ack;
            sl_reads    = vecs[v].reads;
            if (vecs[v].rst) do_reset();
            clear_logs();
            pulse_req(vecs[v].req);
            wait_runs(vecs[v].n_runs);
            check($sformatf("v%0d runs", v), 32'(runs.size()), 32'(vecs[v].n_runs));
            check($sformatf("v%0d writes", v), 32'(wr_acc.size()), 32'(vecs[v].n_wr));
            check($sformatf("v%0d reads", v), 32'(rd_acc.size()), 32'(vecs[v].n_rd));
            check($sformatf("v%0d wstb len", v), 32'(last_wlen), 32'(vecs[v].wlen));
            check($sformatf("v%0d busy end", v), 32'(o_busy), 32'd0);
            for (int i = 0; i < vecs[v].n_runs && i < runs.size(); i++) begin
                logic [2:0] eg;
                eg = (i == 0) ? vecs[v].g0 : (i == 1) ? vecs[v].g1 : vecs[v].g2;
                check($sformatf("v%0d run%0d grant", v, i), 32'(runs[i].g), 32'(eg));
                check($sformatf("v%0d run%0d err", v, i), 32'(runs[i].e), 32'(vecs[v].no_ack));
                if (i < wr_acc.size()) begin
                    check($sformatf("v%0d run%0d wdata", v, i), wr_data[i], {29'h0, eg});
                    if (vecs[v].no_ack)
                        check($sformatf("v%0d run%0d timeout", v, i),
                              32'(runs[i].edge_n - wr_acc[i]), 32'(AT + 1));
                end
            end
        end

        // Re-queue: requester 2 re-requests in its DONE cycle; requester 0 queued meanwhile.
        sl_wr_stall = 0; sl_no_ack = 1'b0; sl_reads = 0;
        do_reset();
        clear_logs();
        pulse_req(4'b0100);
        for (int i = 0; i < 200 && wr_acc.size() == 0; i++) @(negedge clk);
        pulse_req(4'b0001);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(negedge clk);
                if (o_done) seen = 1'b1;
            end
            check("rq done seen", 32'(seen), 32'd1);
            check("rq busy in done", 32'(o_busy), 32'd1);
            i_req = 4'b0100;
            @(negedge clk);
            i_req = '0;
        end
        wait_runs(3);
        check("rq runs", 32'(runs.size()), 32'd3);
        if (runs.size() == 3) begin
            check("rq grant0", 32'(runs[0].g), 32'd2);
            check("rq grant1", 32'(runs[1].g), 32'd0);
            check("rq grant2", 32'(runs[2].g), 32'd2);
        end
        if (runs.size() >= 1 && wr_acc.size() >= 2)
            check("rq done->next wr", 32'(wr_acc[1] - runs[0].edge_n), 32'd3);

        // Reset while a status read is stalled, then a fresh request for requester 2.
        do_reset();
        clear_logs();
        sl_rd_stall = 1'b1;
        pulse_req(4'b0001);
        begin
            bit in_rd;
            in_rd = 1'b0;
            for (int i = 0; i < 400 && !in_rd; i++) begin
                @(negedge clk);
                if (wb.o_wb_stb && !wb.o_wb_we) in_rd = 1'b1;
            end
            check("rst reached rd", 32'(in_rd), 32'd1);
        end
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check_outputs_zero("midrst");
        sl_rd_stall = 1'b0;
        clear_logs();
        pulse_req(4'b0100);
        wait_runs(1);
        check("post rst runs", 32'(runs.size()), 32'd1);
        if (runs.size() == 1) begin
            check("post rst grant", 32'(runs[0].g), 32'd2);
            check("post rst err", 32'(runs[0].e), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/chaser_sched.md
# chaser_sched

Round-robin scheduler that shares one LED-chaser Wishbone peripheral between up to NREQ requesters. It latches run requests, grants one at a time, and starts the chaser with a pipelined Wishbone write. It then polls the chaser's status word until the sweep finishes and reports completion before granting the next requester. It sits between the request sources (buttons, debug bus, UART command decoder) and the chaser's slave port.

## Interface
- NREQ, 4: number of requesters (2..8).
- POLL_GAP, 64: idle cycles between status polls (≥1).
- ACK_TIMEOUT, 15: max cycles waiting for ack after the strobe is accepted (≥1).

- i_clk  in  1  system clock; sole clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  NREQ  per-requester run request; any cycle high sets that requester's pending bit.
- o_busy  out  1  high from grant until completion or abort.
- o_grant  out  3  index of requester currently served; valid while o_busy.
- o_done  out  1  one-cycle pulse: run finished normally.
- o_err  out  1  one-cycle pulse: run aborted by ack timeout.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master controls.
- o_wb_addr  out  1  always 0.
- o_wb_data  out  32  {29'h0, o_grant}.
- i_wb_stall, i_wb_ack  in  1 each  slave stall and ack.
- i_wb_data  in  32  read data; bits [4:0] = chaser step, 0 = idle.

## Operation
- pending[NREQ-1:0]: bit k set on i_req[k]; cleared when requester k's run ends (done or err). Set and clear in the same cycle: set wins, so the requester is re-queued.
- Round-robin pointer ptr, reset 0. The grant is the first pending bit at or after ptr, wrapping. When a run ends, ptr = grant+1 mod NREQ.
- States:
  - IDLE: if any pending bit is set, latch o_grant and go to WR.
  - WR: cyc=stb=we=1. Stay while i_wb_stall=1. When stall=0, drop stb and go to WACK.
  - WACK: cyc=1. On ack, drop cyc and go to GAP.
  - GAP: count POLL_GAP cycles, then go to RD.
  - RD: cyc=stb=1, we=0. Stay while stall=1. When stall=0, go to RACK.
  - RACK: cyc=1. On ack, drop cyc. If i_wb_data[4:0]==0, go to DONE; otherwise go to GAP.
  - DONE: pulse o_done, clear pending[o_grant], advance ptr, go to IDLE.
- Timeout: a counter runs in WACK and RACK. If it reaches ACK_TIMEOUT cycles without ack, drop cyc, pulse o_err, clear pending[o_grant], advance ptr, go to IDLE.
- An ack seen outside WACK or RACK is ignored.
- cyc never stays high across GAP. stb is high only in WR and RD.
- o_busy = (state != IDLE).

## Timing
- Reset (synchronous; also mid-transaction): state IDLE; pending, ptr and the counters go to 0. All outputs are 0 on the following cycle: cyc, stb, we, busy, done, err, grant, data. The bus transaction in flight is abandoned and the cycle drops immediately.
- i_req[k] high at edge t: pending[k] is 1 after t. If IDLE, state=WR and cyc/stb are high after t+1.
- Accepted write strobe (stall=0) at edge s: stb=0 after s.
- Ack at edge a in WACK: cyc=0 after a; the first read strobe appears POLL_GAP cycles later.
- Idle status ack at edge r: o_done is high for the single cycle after r, and IDLE follows. The next grant's stb appears at the earliest 2 cycles after o_done.
- The timeout counter starts at 0 on entry to WACK or RACK. o_err asserts in the cycle after the counter reaches ACK_TIMEOUT.

## Test plan
- Single request, ideal slave (no stall, ack in 1 cycle, status reads 5 twice then 0): i_req=0001 -> one write with data 0, three reads spaced POLL_GAP+2 cycles apart, o_done pulses once, grant=0, pending=0.
- i_req=1011 in one cycle -> runs in grant order 0,1,3, each with its own o_done pulse; ptr ends at 0; no overlapping cyc.
- Slave holds stall for 7 cycles on the write -> stb stays high for 8 cycles, exactly one write accepted, the sequence otherwise unchanged.
- Slave never acks the write -> o_err pulses ACK_TIMEOUT+1 cycles after the accepted strobe; cyc is low from then on; the next pending requester is granted.
- i_req[2] pulsed again during requester 2's run, in the same cycle as DONE -> pending[2] stays 1 and a second run for requester 2 follows (it is served after any other pending requester per ptr).
- i_reset asserted in RD with stall=1 -> the next cycle shows all outputs 0 and IDLE; a new i_req=0100 after reset is served normally with grant=2.
